// File: rtl/serial_paralelo_pkg.sv
// Shared constants and state encoding for the serial link receiver (comma, byte width, FSM states).
package serial_paralelo_pkg;

  localparam int          DATA_WIDTH      = 8;
  localparam logic [7:0]  COMMA_BC        = 8'hBC;
  localparam int          BC_REQUIRED_DEF = 4;
  localparam int          BC_CNT_W        = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  function automatic logic is_comma_byte(input logic [DATA_WIDTH-1:0] b);
    return b == COMMA_BC;
  endfunction

endpackage

// File: rtl/serial_paralelo_if.sv
// Serial-in / byte-out link bundle; master drives the serial bit, slave returns the decoded bytes.
interface serial_paralelo_if;
  import serial_paralelo_pkg::*;

  logic                  data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  byte_tick;
  logic                  active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_tick,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_tick,
    output active
  );

endinterface

// File: rtl/serial_paralelo_comma_detector.sv
// Combinational compare of a candidate byte against the idle comma.
module serial_paralelo_comma_detector
  import serial_paralelo_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] byte_in,
  output logic                  is_comma
);

  assign is_comma = is_comma_byte(byte_in);

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: hunts bit-granular for the comma, counts aligned commas, then
// rebuilds data bytes (MSB first) with a valid flag held for the whole byte period.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter int BC_REQUIRED = BC_REQUIRED_DEF
) (
  input logic              clk_32f,
  input logic              reset,
  serial_paralelo_if.slave link
);

  localparam logic [BC_CNT_W-1:0] BC_TARGET = BC_CNT_W'(BC_REQUIRED);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] next_byte;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            bit_cnt;
  logic [BC_CNT_W-1:0]   bc_cnt;
  logic [BC_CNT_W-1:0]   bc_inc;
  logic                  valid_q;
  logic                  tick_q;
  logic                  active_q;
  logic                  is_comma;

  assign next_byte = {shreg[DATA_WIDTH-2:0], link.data_in};
  assign bc_inc    = bc_cnt + 1'b1;

  serial_paralelo_comma_detector u_comma (
    .byte_in  (next_byte),
    .is_comma (is_comma)
  );

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state    <= SEARCH;
      shreg    <= '0;
      bit_cnt  <= '0;
      bc_cnt   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      tick_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      shreg  <= next_byte;
      tick_q <= 1'b0;
      case (state)
        SEARCH: begin
          if (is_comma) begin
            bit_cnt <= '0;
            bc_cnt  <= {{(BC_CNT_W-1){1'b0}}, 1'b1};
            // A single-comma requirement is already met by the hunt hit itself.
            if (BC_TARGET == {{(BC_CNT_W-1){1'b0}}, 1'b1}) begin
              state    <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end
        end
        SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            tick_q <= 1'b1;
            if (is_comma) begin
              bc_cnt <= bc_inc;
              if (bc_inc == BC_TARGET) begin
                state    <= ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              state  <= SEARCH;
              bc_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            tick_q <= 1'b1;
            if (is_comma) begin
              valid_q <= 1'b0;
            end else begin
              data_q  <= next_byte;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= SEARCH;
          bc_cnt <= '0;
        end
      endcase
    end
  end

  assign link.data_out  = data_q;
  assign link.valid_out = valid_q;
  assign link.byte_tick = tick_q;
  assign link.active    = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench: serial bytes MSB first, outputs checked against hand-computed vectors each byte.
module tb_serial_paralelo;
  import serial_paralelo_pkg::*;

  typedef struct {
    logic [7:0] tx;
    logic       tick;
    logic       vld;
    logic [7:0] dat;
    logic       act;
  } vec_t;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  serial_paralelo_if link ();

  serial_paralelo #(.BC_REQUIRED(4)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .link    (link)
  );

  always #5 clk_32f = ~clk_32f;

  int         n_cmp = 0;
  int         n_bad = 0;
  vec_t       vec[$];
  string      cur_test;
  logic       mid_tick;
  logic       mid_vld;
  logic [7:0] mid_dat;
  logic       prev_vld;
  logic [7:0] prev_dat;

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_out(input string tag, input logic tick, input logic vld,
                           input logic [7:0] dat, input logic act);
    cmp({tag, ".byte_tick"}, {7'd0, link.byte_tick}, {7'd0, tick});
    cmp({tag, ".valid_out"}, {7'd0, link.valid_out}, {7'd0, vld});
    cmp({tag, ".data_out"},  link.data_out, dat);
    cmp({tag, ".active"},    {7'd0, link.active}, {7'd0, act});
  endtask

  // Drive one bit, let the DUT sample it, and return 1 time unit past the edge.
  task automatic send_bit(input logic b);
    link.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i == 4) begin
        mid_tick = link.byte_tick;
        mid_vld  = link.valid_out;
        mid_dat  = link.data_out;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      send_bit(1'($urandom_range(0, 1)));
      check_out($sformatf("%s.rst%0d", cur_test, c), 1'b0, 1'b0, 8'h00, 1'b0);
    end
    reset    = 1'b0;
    prev_vld = 1'b0;
    prev_dat = 8'h00;
  endtask

  function automatic void add(input logic [7:0] tx, input logic tick, input logic vld,
                              input logic [7:0] dat, input logic act);
    vec_t v;
    v.tx = tx; v.tick = tick; v.vld = vld; v.dat = dat; v.act = act;
    vec.push_back(v);
  endfunction

  // Mid-byte: no tick, previous byte's valid/data still held.
  task automatic run_vec();
    foreach (vec[i]) begin
      send_byte(vec[i].tx);
      cmp($sformatf("%s.v%0d.mid_tick", cur_test, i), {7'd0, mid_tick}, 8'd0);
      cmp($sformatf("%s.v%0d.mid_vld", cur_test, i), {7'd0, mid_vld}, {7'd0, prev_vld});
      cmp($sformatf("%s.v%0d.mid_dat", cur_test, i), mid_dat, prev_dat);
      check_out($sformatf("%s.v%0d", cur_test, i), vec[i].tick, vec[i].vld, vec[i].dat, vec[i].act);
      prev_vld = vec[i].vld;
      prev_dat = vec[i].dat;
    end
    vec.delete();
  endtask

  initial begin
    link.data_in = 1'b0;
    #1;

    cur_test = "reset";
    do_reset(3);

    cur_test = "idle_data";
    add(8'hBC, 1'b0, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b1);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b1);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b1);
    add(8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1);
    add(8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1);
    add(8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1);
    add(8'hBC, 1'b1, 1'b0, 8'hFF, 1'b1);
    add(8'hBC, 1'b1, 1'b0, 8'hFF, 1'b1);
    run_vec();

    cur_test = "offset3";
    do_reset(2);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    add(8'hBC, 1'b0, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b1);
    add(8'h81, 1'b1, 1'b1, 8'h81, 1'b1);
    run_vec();

    cur_test = "broken_run";
    do_reset(2);
    add(8'hBC, 1'b0, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'h12, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b0, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b1);
    add(8'h77, 1'b1, 1'b1, 8'h77, 1'b1);
    run_vec();

    // Reset lands halfway through the next byte while valid data is showing.
    cur_test = "mid_reset";
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check_out("mid_reset.before", 1'b0, 1'b1, 8'h77, 1'b1);
    reset = 1'b1;
    send_bit(1'b1);
    check_out("mid_reset.after", 1'b0, 1'b0, 8'h00, 1'b0);
    reset    = 1'b0;
    prev_vld = 1'b0;
    prev_dat = 8'h00;
    add(8'hBC, 1'b0, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0);
    add(8'hBC, 1'b1, 1'b0, 8'h00, 1'b1);
    add(8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1);
    run_vec();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
